// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer and controller for the 32-bit PC register.
// The block chooses the next PC from five sources: the boot vector, the
// sequential increment, a branch/jump target, the trap vector and the trap
// return address. It also drives the instruction fetch handshake and holds
// the trap state (mepc, mcause).
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   pc_i                    current PC register value
//   pc_ld_o, pc_data_o      PC load strobe and load value (combinational)
//   fetch_req_o/fetch_gnt_i instruction fetch handshake
//   advance_i               current instruction retires this cycle
//   br_taken_i/br_target_i  redirect request and its target (needs advance_i)
//   mret_i                  trap return (needs advance_i)
//   trap_req_i/trap_cause_i trap request and its cause (needs advance_i)
//   mtvec_i                 trap vector base
//   mepc_o, mcause_o        saved return PC and latched trap cause
//   trap_ack_o              high while the trap vector is being loaded
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] INC       = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_ld_o,
  output logic [31:0] pc_data_o,
  output logic        fetch_req_o,
  input  logic        fetch_gnt_i,
  input  logic        advance_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        mret_i,
  input  logic        trap_req_i,
  input  logic [3:0]  trap_cause_i,
  input  logic [31:0] mtvec_i,
  output logic [31:0] mepc_o,
  output logic [3:0]  mcause_o,
  output logic        trap_ack_o
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_TRAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mepc, w_mepc_nxt;
  logic [3:0]  r_mcause, w_mcause_nxt;
  logic        w_ld, w_req, w_ack;
  logic [31:0] w_data, w_seq;

  // Sequential next PC; plain 32-bit add, wraps silently.
  assign w_seq = pc_i + INC;

  always_comb begin
    w_state_nxt  = r_state;
    w_mepc_nxt   = r_mepc;
    w_mcause_nxt = r_mcause;
    w_ld         = 1'b0;
    w_req        = 1'b0;
    w_ack        = 1'b0;
    w_data       = w_seq;
    case (r_state)
      S_BOOT: begin
        w_ld        = 1'b1;
        w_data      = RESET_VEC;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (fetch_gnt_i) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (advance_i) begin
          if (trap_req_i) begin
            // No load now; the vector is loaded from TRAP next cycle.
            w_mcause_nxt = trap_cause_i;
            if (!mret_i) w_mepc_nxt = br_taken_i ? br_target_i : w_seq;
            w_state_nxt = S_TRAP;
          end else begin
            w_ld        = 1'b1;
            w_state_nxt = S_FETCH;
            if (mret_i)          w_data = r_mepc;
            else if (br_taken_i) w_data = br_target_i;
            else                 w_data = w_seq;
          end
        end
      end
      S_TRAP: begin
        w_ld        = 1'b1;
        w_ack       = 1'b1;
        w_data      = mtvec_i;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_BOOT;
      r_mepc   <= 32'h0;
      r_mcause <= 4'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_mepc   <= w_mepc_nxt;
      r_mcause <= w_mcause_nxt;
    end
  end

  // Reset overrides everything: no load and no fetch while it is asserted,
  // so a reset mid-operation never leaks a stray PC update or request.
  assign pc_ld_o     = w_ld  & ~rst_i;
  assign fetch_req_o = w_req & ~rst_i;
  assign trap_ack_o  = w_ack & ~rst_i;
  // Instruction addresses are always word aligned, whatever the source.
  assign pc_data_o   = {w_data[31:2], 2'b00};
  assign mepc_o      = r_mepc;
  assign mcause_o    = r_mcause;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_ld_o;
  logic [31:0] pc_data_o;
  logic        fetch_req_o;
  logic        fetch_gnt_i = 1'b0;
  logic        advance_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        mret_i = 1'b0;
  logic        trap_req_i = 1'b0;
  logic [3:0]  trap_cause_i = '0;
  logic [31:0] mtvec_i = '0;
  logic [31:0] mepc_o;
  logic [3:0]  mcause_o;
  logic        trap_ack_o;

  int total = 0;
  int bad   = 0;

  // Reference model: what the controller is doing (as a phase number) plus
  // the architectural trap registers.
  localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_TRAP = 3;
  int          m_phase = P_BOOT;
  logic [31:0] m_mepc = '0;
  logic [3:0]  m_mcause = '0;

  pc_seq_ctrl #(.RESET_VEC(RV), .INC(32'd4)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .pc_ld_o(pc_ld_o),
    .pc_data_o(pc_data_o), .fetch_req_o(fetch_req_o), .fetch_gnt_i(fetch_gnt_i),
    .advance_i(advance_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .mret_i(mret_i), .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i),
    .mtvec_i(mtvec_i), .mepc_o(mepc_o), .mcause_o(mcause_o), .trap_ack_o(trap_ack_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare outputs to the model, clock, update model.
  task automatic step(input bit chk_en, input logic rst, input logic gnt,
                      input logic adv, input logic br, input logic [31:0] tgt,
                      input logic mret, input logic trap, input logic [3:0] cause,
                      input logic [31:0] mtvec, input logic [31:0] pc);
    logic        e_ld, e_req, e_ack;
    logic [31:0] e_data, nxt_pc;
    rst_i = rst; fetch_gnt_i = gnt; advance_i = adv; br_taken_i = br;
    br_target_i = tgt; mret_i = mret; trap_req_i = trap; trap_cause_i = cause;
    mtvec_i = mtvec; pc_i = pc;
    nxt_pc = pc + 32'd4;
    e_ld = 1'b0; e_req = 1'b0; e_ack = 1'b0; e_data = '0;
    if (!rst) begin
      if (m_phase == P_BOOT) begin e_ld = 1'b1; e_data = RV; end
      if (m_phase == P_FETCH) e_req = 1'b1;
      if (m_phase == P_TRAP) begin e_ld = 1'b1; e_ack = 1'b1; e_data = mtvec; end
      if (m_phase == P_EXEC && adv && !trap) begin
        e_ld = 1'b1;
        e_data = mret ? m_mepc : (br ? tgt : nxt_pc);
      end
    end
    e_data = e_data & 32'hFFFF_FFFC;
    #2;
    if (chk_en) begin
      chk("pc_ld", {31'b0, pc_ld_o}, {31'b0, e_ld});
      if (e_ld) chk("pc_data", pc_data_o, e_data);
      chk("fetch_req", {31'b0, fetch_req_o}, {31'b0, e_req});
      chk("trap_ack", {31'b0, trap_ack_o}, {31'b0, e_ack});
      chk("mepc", mepc_o, m_mepc);
      chk("mcause", {28'b0, mcause_o}, {28'b0, m_mcause});
    end
    @(posedge clk);
    if (rst) begin
      m_phase = P_BOOT; m_mepc = '0; m_mcause = '0;
    end else begin
      case (m_phase)
        P_BOOT:  m_phase = P_FETCH;
        P_FETCH: if (gnt) m_phase = P_EXEC;
        P_EXEC:  if (adv) begin
                   if (trap) begin
                     m_mcause = cause;
                     if (!mret) m_mepc = br ? tgt : nxt_pc;
                     m_phase = P_TRAP;
                   end else m_phase = P_FETCH;
                 end
        default: m_phase = P_FETCH;
      endcase
    end
    #1;
  endtask

  initial begin
    // Reset held two cycles; DUT state is unknown before the first edge.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // BOOT: load of RESET_VEC, then fetch request with registers cleared.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    chk("boot_fetch_req", {31'b0, fetch_req_o}, 32'd1);
    // Sequential run: gnt after two wait cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h100);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h104);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h104);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h108);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h108);
    // Branch with stall: redirect ignored until advance.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10C);
    repeat (3) step(1, 0, 0, 0, 1, 32'h2003, 0, 0, 0, 0, 32'h10C);
    step(1, 0, 0, 1, 1, 32'h2003, 0, 0, 0, 0, 32'h10C);
    // Trap with simultaneous branch, then trap return.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    step(1, 0, 0, 1, 1, 32'h400, 0, 1, 4'hB, 32'h8001, 32'h200);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8001, 32'h200);
    chk("trap_mepc", mepc_o, 32'h400);
    chk("trap_mcause", {28'b0, mcause_o}, 32'hB);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8000);
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h8000);
    // Wrap of the sequential increment.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    // Trap together with mret keeps mepc.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 1, 32'h7777, 1, 1, 4'h3, 32'h4000, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 32'h0);
    // Reset while a fetch is pending.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000);
    chk("rst_mepc_clr", mepc_o, 32'h0);
    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pcv;
      pcv = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      step(1, ($urandom_range(0, 40) == 0), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom), $urandom, pcv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and controller for the 32-bit program counter register.
- Owns the PC load strobe and load value, and the fetch request handshake.
- Selects among boot vector, sequential increment, branch/jump target, trap vector and trap return.
- Holds the trap-return address (mepc) and trap cause; sits between decode/execute, the CSR file and the PC register.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded after reset.
INC, 4, sequential increment added to current PC.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
pc_i  input  32  current PC register value
pc_ld_o  output  1  PC load strobe, combinational; PC updates at next edge
pc_data_o  output  32  PC load value, combinational
fetch_req_o  output  1  instruction fetch request
fetch_gnt_i  input  1  fetch accepted / instruction available
advance_i  input  1  current instruction completes this cycle
br_taken_i  input  1  branch/jump redirect, qualified by advance_i
br_target_i  input  32  redirect target
mret_i  input  1  trap return, qualified by advance_i
trap_req_i  input  1  trap/interrupt request, qualified by advance_i
trap_cause_i  input  4  cause code for trap_req_i
mtvec_i  input  32  trap vector base
mepc_o  output  32  saved return PC
mcause_o  output  4  latched trap cause
trap_ack_o  output  1  one-cycle pulse when trap vector is loaded

Behaviour:
- Reset (rst_i high at edge): state=BOOT, mepc_o=0, mcause_o=0. Registered outputs are 0 after reset.
- Reset dominates all other inputs. Reset asserted mid-operation abandons any pending fetch: fetch_req_o=0 the cycle after reset is sampled, and nothing is loaded.
- States: BOOT, FETCH, EXEC, TRAP.
- BOOT: pc_ld_o=1, pc_data_o=RESET_VEC. Next state FETCH.
- FETCH:
  - fetch_req_o=1 and pc_ld_o=0.
  - fetch_req_o is held until fetch_gnt_i=1 in the same cycle, then EXEC.
  - No gnt: stay in FETCH.
- EXEC:
  - fetch_req_o=0.
  - advance_i=0: pc_ld_o=0, stay in EXEC. br_taken_i, mret_i and trap_req_i are ignored.
  - advance_i=1, priority trap > mret > branch > sequential:
    - trap_req_i: pc_ld_o=0; mcause_o<=trap_cause_i; next state TRAP.
      - mepc_o<=br_target_i if br_taken_i, else pc_i+INC.
      - If mret_i is also set: mepc_o unchanged.
    - mret_i: pc_ld_o=1, pc_data_o=mepc_o, next FETCH.
    - br_taken_i: pc_ld_o=1, pc_data_o=br_target_i, next FETCH.
    - otherwise: pc_ld_o=1, pc_data_o=pc_i+INC, next FETCH.
- TRAP:
  - pc_ld_o=1, pc_data_o={mtvec_i[31:2],2'b00}.
  - trap_ack_o=1 for exactly this cycle. trap_ack_o is a Moore output of state TRAP.
  - Next state FETCH.
- Address alignment: every pc_data_o value has bits [1:0] forced to 2'b00, including RESET_VEC, br_target_i and mepc_o sources. mepc_o is stored as computed, unmasked.
- Arithmetic: pc_i+INC is 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
- pc_ld_o is never asserted in FETCH. At most one load per instruction plus one per trap entry.
- mepc_o and mcause_o change only on trap entry in EXEC, or on reset.

Test Plan:
- Reset, RESET_VEC=32'h100, rst_i held 2 cycles then released -> pc_ld_o=1, pc_data_o=32'h100 in BOOT; next cycle fetch_req_o=1; mepc_o=0, mcause_o=0.
- Sequential run: pc_i=32'h100; gnt after 2 wait cycles (fetch_req_o held 3 cycles); then advance_i=1 -> pc_ld_o=1, pc_data_o=32'h104; repeat 3 instructions -> 32'h108, 32'h10C.
- Branch with stall: advance_i=0 for 3 cycles with br_taken_i=1 -> no load. Then advance_i=1, br_taken_i=1, br_target_i=32'h2003 -> pc_data_o=32'h2000.
- Trap with simultaneous branch: pc_i=32'h200, trap_req_i=1, br_taken_i=1, br_target_i=32'h400, trap_cause_i=4'hB, mtvec_i=32'h8001 -> no load that cycle; next cycle pc_data_o=32'h8000 and trap_ack_o=1 for one cycle; mepc_o=32'h400, mcause_o=4'hB. Later mret_i with advance_i -> pc_data_o=32'h400.
- Wrap: pc_i=32'hFFFF_FFFC, advance_i=1, no redirect -> pc_data_o=32'h0000_0000.
- Reset mid-FETCH: fetch_req_o=1 awaiting gnt, rst_i=1 one cycle -> fetch_req_o=0 next cycle; BOOT load of RESET_VEC follows; mepc_o/mcause_o cleared.
